ask_bit_deframer: RTL and testbench

Recovers asynchronous start/stop-framed characters from the 1-bit `rx` line produced by the ASK threshold detector (idle high, start bit low), sampling each bit at mid-period using a runtime clocks-per-bit divisor. Sits directly downstream of the detector in the ASK receive chain. Emits each character LSB-first-assembled on an AXI-stream-style output with a one-entry holding register. Flags framing errors and overruns as single-cycle pulses.

---
 rtl/ask_bit_deframer_pkg.sv | 31 +++
 rtl/ask_rx_holding_reg.sv | 45 ++++
 rtl/ask_bit_deframer.sv | 176 +++++++++++++++++
 tb/tb_ask_bit_deframer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ask_bit_deframer_pkg.sv
// Shared definitions for the ASK receive chain: line levels, divisor limit,
// FSM state encodings (also used by the auto-baud block) and a width helper.
package ask_bit_deframer_pkg;

  // Idle level of the detector output; a start bit is the opposite level.
  localparam logic ASK_RX_IDLE = 1'b1;

  // Smallest clocks-per-bit value that gives a usable mid-bit sample point.
  localparam int ASK_MIN_CPB = 4;

  // 3-bit state encodings, kept as plain localparams so other blocks can reuse them.
  localparam logic [2:0] ASK_ST_IDLE  = 3'd0;
  localparam logic [2:0] ASK_ST_START = 3'd1;
  localparam logic [2:0] ASK_ST_DATA  = 3'd2;
  localparam logic [2:0] ASK_ST_STOP  = 3'd3;
  localparam logic [2:0] ASK_ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ASK_ST_IDLE,
    ST_START = ASK_ST_START,
    ST_DATA  = ASK_ST_DATA,
    ST_STOP  = ASK_ST_STOP,
    ST_BREAK = ASK_ST_BREAK
  } ask_rx_state_t;

  // Width of a bit index that addresses 0..data_bits-1 exactly.
  function automatic int ask_idx_width(input int data_bits);
    return (data_bits > 1) ? $clog2(data_bits) : 1;
  endfunction

endpackage

// File: rtl/ask_rx_holding_reg.sv
// One-entry output register for received characters.
//
// Handshake: a character transfers to the consumer on every rising clk edge
// where o_tvalid and o_tready are both 1. Once o_tvalid is 1 it stays 1 and
// o_tdata stays unchanged until that transfer happens. A load arriving in the
// same cycle as a transfer replaces the outgoing character (o_tvalid stays 1);
// a load arriving while the entry is full and not transferring is dropped and
// reported by a one-cycle full_drop pulse.
module ask_rx_holding_reg #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 o_tready,
  output logic [DATA_BITS-1:0] o_tdata,
  output logic                 o_tvalid,
  output logic                 full_drop
);

  logic w_xfer;
  logic w_accept_load;

  assign w_xfer        = o_tvalid & o_tready;
  assign w_accept_load = load & (~o_tvalid | o_tready);

  // Entry contents, valid flag and drop pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_tdata   <= '0;
      o_tvalid  <= 1'b0;
      full_drop <= 1'b0;
    end else begin
      full_drop <= load & o_tvalid & ~o_tready;
      if (w_accept_load) begin
        o_tdata  <= load_data;
        o_tvalid <= 1'b1;
      end else if (w_xfer) begin
        o_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ask_bit_deframer.sv
// Start/stop character deframer for the ASK detector output. Detects the start
// edge, samples each bit near mid-period with a divisor latched per character,
// and hands completed characters to a one-entry valid/ready register.
module ask_bit_deframer
  import ask_bit_deframer_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] clks_per_bit,
  output logic [DATA_BITS-1:0] o_tdata,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 frame_err,
  output logic                 overrun,
  output ask_rx_state_t        o_dbg_state
);

  localparam int IDX_W = ask_idx_width(DATA_BITS);
  localparam logic [IDX_W-1:0]     LAST_BIT = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(1);

  ask_rx_state_t          r_state;
  ask_rx_state_t          w_state_next;
  logic                   r_rx_q;
  logic [DIV_WIDTH-1:0]   r_cnt;
  logic [DIV_WIDTH-1:0]   r_cpb;
  logic [DIV_WIDTH-1:0]   r_half;
  logic [IDX_W-1:0]       r_bitidx;
  logic [DATA_BITS-1:0]   r_shreg;
  logic                   r_frame_err;

  logic                   w_rst;
  logic                   w_start_edge;
  logic                   w_half_hit;
  logic                   w_bit_hit;
  logic                   w_load;
  logic                   w_frame_err_next;
  logic                   w_full_drop;

  assign w_rst      = reset | clear;
  assign w_half_hit = (r_cnt == (r_half - CNT_ONE));
  assign w_bit_hit  = (r_cnt == (r_cpb - CNT_ONE));

  assign frame_err   = r_frame_err;
  assign overrun     = w_full_drop;
  assign o_dbg_state = r_state;

  // Registered copy of the line for edge detection and sampling.
  always_ff @(posedge clk) begin
    if (w_rst) r_rx_q <= ASK_RX_IDLE;
    else       r_rx_q <= rx;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (w_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode plus the delivery and framing-error strobes.
  always_comb begin
    w_state_next     = r_state;
    w_start_edge     = 1'b0;
    w_load           = 1'b0;
    w_frame_err_next = 1'b0;
    if (!enable) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_rx_q == ASK_RX_IDLE && rx != ASK_RX_IDLE) begin
            w_start_edge = 1'b1;
            w_state_next = ST_START;
          end
        end
        ST_START: begin
          // A line back at idle by mid start bit was only a glitch.
          if (w_half_hit)
            w_state_next = (r_rx_q == ASK_RX_IDLE) ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (w_bit_hit && r_bitidx == LAST_BIT) w_state_next = ST_STOP;
        end
        ST_STOP: begin
          if (w_bit_hit) begin
            if (r_rx_q == ASK_RX_IDLE) begin
              w_load       = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_frame_err_next = 1'b1;
              w_state_next     = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // Hold off until the line idles so a stuck-low line is not re-read.
          if (r_rx_q == ASK_RX_IDLE) w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Bit timing counters, latched divisor and the assembly shift register.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_cnt    <= '0;
      r_cpb    <= '0;
      r_half   <= '0;
      r_bitidx <= '0;
      r_shreg  <= '0;
    end else if (!enable) begin
      r_cnt    <= '0;
      r_bitidx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_start_edge) begin
            r_cpb  <= clks_per_bit;
            r_half <= clks_per_bit >> 1;
          end
        end
        ST_START: begin
          if (w_half_hit) begin
            r_cnt    <= '0;
            r_bitidx <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (w_bit_hit) begin
            r_shreg[r_bitidx] <= r_rx_q;
            r_cnt             <= '0;
            r_bitidx          <= r_bitidx + IDX_ONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (w_bit_hit) r_cnt <= '0;
          else           r_cnt <= r_cnt + CNT_ONE;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Framing error pulse, one cycle after the bad stop sample.
  always_ff @(posedge clk) begin
    if (w_rst) r_frame_err <= 1'b0;
    else       r_frame_err <= w_frame_err_next;
  end

  ask_rx_holding_reg #(
    .DATA_BITS (DATA_BITS)
  ) u_hold (
    .clk       (clk),
    .reset     (w_rst),
    .load      (w_load),
    .load_data (r_shreg),
    .o_tready  (o_tready),
    .o_tdata   (o_tdata),
    .o_tvalid  (o_tvalid),
    .full_drop (w_full_drop)
  );

endmodule

// File: tb/tb_ask_bit_deframer.sv
// Directed bench for ask_bit_deframer: table of whole characters plus
// hand-written sequences for glitch, overrun, enable and reset corner cases.
module tb_ask_bit_deframer;
  import ask_bit_deframer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clear, enable, rx, o_tready;
  logic [15:0] clks_per_bit;
  logic [7:0]  o_tdata;
  logic        o_tvalid, frame_err, overrun;
  ask_rx_state_t o_dbg_state;

  ask_bit_deframer #(.DATA_BITS(8), .DIV_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .enable       (enable),
    .rx           (rx),
    .clks_per_bit (clks_per_bit),
    .o_tdata      (o_tdata),
    .o_tvalid     (o_tvalid),
    .o_tready     (o_tready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard ----------------
  int rise_cnt = 0, rise_cyc = 0, ferr_cnt = 0, ferr_cyc = 0, ovr_cnt = 0, ovr_cyc = 0;
  logic [7:0] rise_data = '0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (o_tvalid && !prev_valid) begin
      rise_cnt  = rise_cnt + 1;
      rise_cyc  = cyc;
      rise_data = o_tdata;
    end
    prev_valid = o_tvalid;
    if (frame_err) begin ferr_cnt = ferr_cnt + 1; ferr_cyc = cyc; end
    if (overrun)   begin ovr_cnt  = ovr_cnt + 1;  ovr_cyc  = cyc; end
    if (o_tvalid && o_tready) got_q.push_back(o_tdata);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends start, 8 data bits LSB first, stop bit, optional extra low tail,
  // then 2 idle cycles. e returns the cycle index of the start edge.
  task automatic send_char(input logic [7:0] d, input int n, input logic stop_bit,
                           input int low_tail, output int e);
    clks_per_bit = 16'(n);
    rx = 1'b0;
    e  = cyc;
    tick(1);
    clks_per_bit = 16'(n + 3);  // must not affect the frame in progress
    tick(n - 1);
    for (int k = 0; k < 8; k++) begin
      rx = d[k];
      tick(n);
    end
    rx = stop_bit;
    tick(n);
    if (low_tail > 0) begin
      rx = 1'b0;
      tick(low_tail);
    end
    rx = 1'b1;
    tick(2);
  endtask

  typedef struct {
    logic [7:0] data;
    int         cpb;
    logic       stop_bit;
    int         low_tail;
    int         lat;       // cycles from start edge to o_tvalid / frame_err
  } vec_t;

  vec_t vecs[8];

  initial begin
    int e, e2, r0, f0, o0;

    vecs[0] = '{8'hA5, 16, 1'b1, 0,  153};
    vecs[1] = '{8'h3C, 16, 1'b0, 40, 153};
    vecs[2] = '{8'h55, 16, 1'b1, 0,  153};
    vecs[3] = '{8'hFF, 4,  1'b1, 0,  39};
    vecs[4] = '{8'h5A, 7,  1'b1, 0,  67};
    vecs[5] = '{8'h81, 4,  1'b1, 0,  39};
    vecs[6] = '{8'h00, 5,  1'b1, 0,  48};
    vecs[7] = '{8'h96, 9,  1'b1, 0,  86};

    reset = 1'b1; clear = 1'b0; enable = 1'b1; rx = 1'b1;
    o_tready = 1'b1; clks_per_bit = 16'd16;
    tick(3);
    reset = 1'b0;
    tick(2);

    // ---- reset state ----
    check("rst_tvalid", 32'(o_tvalid), 0);
    check("rst_tdata", 32'(o_tdata), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_state", 32'(o_dbg_state), 32'(ASK_ST_IDLE));

    // ---- table of whole characters, consumer always ready ----
    for (int i = 0; i < 8; i++) begin
      r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      send_char(vecs[i].data, vecs[i].cpb, vecs[i].stop_bit, vecs[i].low_tail, e);
      tick(3);
      check($sformatf("v%0d_rise_cnt", i), 32'(rise_cnt - r0), vecs[i].stop_bit ? 1 : 0);
      check($sformatf("v%0d_ferr_cnt", i), 32'(ferr_cnt - f0), vecs[i].stop_bit ? 0 : 1);
      check($sformatf("v%0d_ovr_cnt", i), 32'(ovr_cnt - o0), 0);
      if (vecs[i].stop_bit) begin
        check($sformatf("v%0d_valid_lat", i), 32'(rise_cyc - e), 32'(vecs[i].lat));
        check($sformatf("v%0d_data", i), 32'(rise_data), 32'(vecs[i].data));
        exp_q.push_back(vecs[i].data);
      end else begin
        check($sformatf("v%0d_ferr_lat", i), 32'(ferr_cyc - e), 32'(vecs[i].lat));
      end
    end

    // ---- 5-cycle low glitch at cpb=16: false start ----
    r0 = rise_cnt; f0 = ferr_cnt;
    clks_per_bit = 16'd16;
    rx = 1'b0; e = cyc;
    tick(5);
    rx = 1'b1;
    while (cyc < e + 8) tick(1);
    check("glitch_state_start", 32'(o_dbg_state), 32'(ASK_ST_START));
    tick(1);
    check("glitch_state_idle", 32'(o_dbg_state), 32'(ASK_ST_IDLE));
    tick(170);
    check("glitch_no_rise", 32'(rise_cnt - r0), 0);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 0);

    // ---- overrun with consumer stalled ----
    o_tready = 1'b0;
    r0 = rise_cnt; o0 = ovr_cnt;
    send_char(8'h11, 4, 1'b1, 0, e);
    check("ovr_first_rise", 32'(rise_cnt - r0), 1);
    check("ovr_first_lat", 32'(rise_cyc - e), 39);
    send_char(8'h22, 4, 1'b1, 0, e);
    check("ovr_pulse_cnt", 32'(ovr_cnt - o0), 1);
    check("ovr_pulse_lat", 32'(ovr_cyc - e), 39);
    check("ovr_keep_data", 32'(o_tdata), 32'h11);
    check("ovr_keep_valid", 32'(o_tvalid), 1);

    // ---- delivery coinciding with a transfer: no overrun ----
    o0 = ovr_cnt;
    e2 = cyc;
    fork
      send_char(8'h22, 4, 1'b1, 0, e);
      begin
        while (cyc < e2 + 38) tick(1);
        o_tready = 1'b1;
        tick(1);
        o_tready = 1'b0;
      end
    join
    exp_q.push_back(8'h11);
    check("swap_no_ovr", 32'(ovr_cnt - o0), 0);
    check("swap_data", 32'(o_tdata), 32'h22);
    check("swap_valid", 32'(o_tvalid), 1);
    o_tready = 1'b1;
    tick(2);
    exp_q.push_back(8'h22);
    check("swap_drained", 32'(o_tvalid), 0);

    // ---- enable dropped at bit 4 ----
    r0 = rise_cnt; f0 = ferr_cnt;
    e2 = cyc;
    fork
      send_char(8'hFF, 16, 1'b1, 0, e);
      begin
        while (cyc < e2 + 85) tick(1);
        enable = 1'b0;
        tick(1);
        check("en_abort_state", 32'(o_dbg_state), 32'(ASK_ST_IDLE));
      end
    join
    enable = 1'b1;
    tick(1);
    check("en_no_rise", 32'(rise_cnt - r0), 0);
    check("en_no_ferr", 32'(ferr_cnt - f0), 0);
    r0 = rise_cnt;
    send_char(8'h0F, 16, 1'b1, 0, e);
    tick(2);
    check("en_after_rise", 32'(rise_cnt - r0), 1);
    check("en_after_lat", 32'(rise_cyc - e), 153);
    check("en_after_data", 32'(rise_data), 32'h0F);
    exp_q.push_back(8'h0F);

    // ---- reset mid-frame with a character held ----
    o_tready = 1'b0;
    r0 = rise_cnt;
    send_char(8'h33, 4, 1'b1, 0, e);
    check("hold_valid", 32'(o_tvalid), 1);
    check("hold_rise", 32'(rise_cnt - r0), 1);
    r0 = rise_cnt; f0 = ferr_cnt;
    e2 = cyc;
    fork
      send_char(8'hF8, 8, 1'b1, 0, e);
      begin
        while (cyc < e2 + 33) tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_valid", 32'(o_tvalid), 0);
        check("mid_rst_data", 32'(o_tdata), 0);
        check("mid_rst_state", 32'(o_dbg_state), 32'(ASK_ST_IDLE));
      end
    join
    check("mid_rst_no_rise", 32'(rise_cnt - r0), 0);
    check("mid_rst_no_ferr", 32'(ferr_cnt - f0), 0);
    o_tready = 1'b1;
    r0 = rise_cnt;
    send_char(8'h81, 4, 1'b1, 0, e);
    tick(2);
    check("post_rst_rise", 32'(rise_cnt - r0), 1);
    check("post_rst_lat", 32'(rise_cyc - e), 39);
    check("post_rst_data", 32'(rise_data), 32'h81);
    exp_q.push_back(8'h81);

    // ---- scoreboard: every accepted character, in order ----
    tick(3);
    check("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        check($sformatf("sb_data_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
